bcd_timer_ctrl: RTL and testbench

- Sequencing controller for a chain of DIGITS external single-digit BCD up/down counters. Each counter has inputs d[3:0], enable, load and up, and output q[3:0].
- Generates the per-digit enable, load and up controls and the preset data. Also handles prescaled ticking, digit-to-digit carry/borrow chaining, and terminal detection. Does not use the counters' carry-out.
- Sits between the front-panel command logic (start/stop/load buttons, already debounced) and the counter chain of the timer/stopwatch datapath.

---
 rtl/bcd_ctrl_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/bcd_timer_ctrl.sv | 153 +++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD timer controller: FSM state encoding,
// BCD digit limits and preset nibble validation.
package bcd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic bcd_valid(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits one tick every PRESCALE cycles while run is
// high; the count holds when run is low and clear forces it back to zero.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned W = $clog2(PRESCALE) + 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = run && (cnt_q == LAST);
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a chain of external BCD up/down counter digits:
// loads presets, ticks the chain through a prescaler and detects terminal counts.
module bcd_timer_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 1000,
   parameter bit          WRAP     = 1'b0
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                cmd_start,
   input  logic                cmd_stop,
   input  logic                cmd_load,
   input  logic                dir_up,
   input  logic [4*DIGITS-1:0] preset,
   input  logic [4*DIGITS-1:0] digit_q,
   output logic [DIGITS-1:0]   digit_en,
   output logic                digit_load,
   output logic                digit_up,
   output logic [4*DIGITS-1:0] digit_d,
   output logic [2:0]          state_o,
   output logic                busy,
   output logic                done,
   output logic                err
);

   state_e              state_q, state_d;
   logic                dir_q, dir_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic [4*DIGITS-1:0] preset_q, preset_d;

   logic              tick, in_run, presc_clear;
   logic [DIGITS-1:0] term;
   logic              all_term, all_zero, preset_ok, halt, carry;

   assign in_run = (state_q == ST_RUN);

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .clr  (clr),
      .run  (in_run),
      .clear(presc_clear),
      .tick (tick)
   );

   // Terminal digit = 9 counting up, 0 counting down; purely combinational on
   // the fed-back counter values so the carry ripples within the tick cycle.
   always_comb begin
      term      = '0;
      all_zero  = 1'b1;
      preset_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         term[i]   = dir_q ? (digit_q[4*i +: 4] == BCD_MAX) : (digit_q[4*i +: 4] == BCD_MIN);
         all_zero  = all_zero & (digit_q[4*i +: 4] == BCD_MIN);
         preset_ok = preset_ok & bcd_valid(preset[4*i +: 4]);
      end
   end

   assign all_term = &term;
   assign halt     = all_term && !(dir_q && WRAP);

   always_comb begin
      digit_en = '0;
      carry    = 1'b1;
      if (state_q == ST_LOAD) begin
         digit_en = '1;
      end else if (in_run && tick && !halt) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_en[i] = carry;
            carry       = carry & term[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      err_d       = err_q;
      preset_d    = preset_q;
      done_d      = 1'b0;
      presc_clear = 1'b0;
      case (state_q)
         ST_LOAD: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         ST_RUN: begin
            done_d = tick && all_term;
            if (cmd_load) begin
               if (preset_ok) begin
                  state_d  = ST_LOAD;
                  preset_d = preset;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cmd_stop) begin
               state_d = ST_PAUSE;
            end else if (tick && halt) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            // Resuming from PAUSE keeps the held prescaler phase.
            if (cmd_load) begin
               if (preset_ok) begin
                  state_d  = ST_LOAD;
                  preset_d = preset;
               end else begin
                  err_d = 1'b1;
               end
            end else if (!cmd_stop && cmd_start &&
                         !(state_q == ST_DONE && !dir_up && all_zero)) begin
               state_d     = ST_RUN;
               dir_d       = dir_up;
               presc_clear = (state_q != ST_PAUSE);
            end
         end
      endcase
      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= ST_IDLE;
         dir_q    <= 1'b1;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         preset_q <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         preset_q <= preset_d;
      end
   end

   assign digit_load = (state_q == ST_LOAD);
   assign digit_d    = digit_load ? preset_q : '0;
   assign digit_up   = dir_q;
   assign state_o    = state_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: two instances (WRAP=0 and WRAP=1) each drive a
// behavioural 2-digit BCD counter chain; checked by directed scenarios and a decimal reference model.
module tb_bcd_timer_ctrl;

   localparam int DIG   = 2;
   localparam int PRESC = 4;
   localparam int MAXV  = 99;
   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;

   logic       clk, clr, cmd_start, cmd_stop, cmd_load, dir_up;
   logic [7:0] preset;
   logic [7:0] dq [2];
   logic [1:0] en [2];
   logic [7:0] dd [2];
   logic [2:0] st [2];
   logic       ld [2], up [2], bz [2], dn [2], er [2];

   int checks = 0;
   int errors = 0;

   bcd_timer_ctrl #(.DIGITS(DIG), .PRESCALE(PRESC), .WRAP(1'b0)) u_nowrap (
      .clk(clk), .clr(clr), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_load(cmd_load),
      .dir_up(dir_up), .preset(preset), .digit_q(dq[0]), .digit_en(en[0]), .digit_load(ld[0]),
      .digit_up(up[0]), .digit_d(dd[0]), .state_o(st[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]));

   bcd_timer_ctrl #(.DIGITS(DIG), .PRESCALE(PRESC), .WRAP(1'b1)) u_wrap (
      .clk(clk), .clr(clr), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_load(cmd_load),
      .dir_up(dir_up), .preset(preset), .digit_q(dq[1]), .digit_en(en[1]), .digit_load(ld[1]),
      .digit_up(up[1]), .digit_d(dd[1]), .state_o(st[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-digit BCD counters, untouched by clr.
   function automatic logic [7:0] chain_next(logic [7:0] q, logic [1:0] e, logic l, logic u,
                                             logic [7:0] d);
      logic [7:0] r;
      logic [3:0] n;
      if (l) return d;
      r = q;
      for (int i = 0; i < DIG; i++) begin
         if (e[i]) begin
            n = q[4*i +: 4];
            if (u) n = (n == 4'd9) ? 4'd0 : n + 4'd1;
            else   n = (n == 4'd0) ? 4'd9 : n - 4'd1;
            r[4*i +: 4] = n;
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      dq[0] <= chain_next(dq[0], en[0], ld[0], up[0], dd[0]);
      dq[1] <= chain_next(dq[1], en[1], ld[1], up[1], dd[1]);
   end

   // Reference model: chain value kept as a decimal integer; instance 1 wraps.
   int         m_state [2], m_pre [2];
   int         m_val [2] = '{0, 0};
   bit         m_dir [2], m_err [2], m_done [2];
   logic [7:0] m_preset [2];

   function automatic int pow10(int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   function automatic int bcd2int(logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction
   function automatic logic [7:0] int2bcd(int v);
      logic [7:0] r;
      r[3:0] = 4'(v % 10);
      r[7:4] = 4'((v / 10) % 10);
      return r;
   endfunction
   function automatic bit nibbles_ok(logic [7:0] b);
      return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
   endfunction
   function automatic bit m_tick(int k);
      return (m_state[k] == S_RUN) && (m_pre[k] == PRESC - 1);
   endfunction
   function automatic bit m_term(int k);
      return m_dir[k] ? (m_val[k] == MAXV) : (m_val[k] == 0);
   endfunction
   function automatic bit m_stops(int k);
      return m_term(k) && !(m_dir[k] && k == 1);
   endfunction
   function automatic logic [1:0] m_en(int k);
      logic [1:0] r = 2'b00;
      if (m_state[k] == S_LOAD) return 2'b11;
      if (!m_tick(k) || m_stops(k)) return 2'b00;
      for (int i = 0; i < DIG; i++) begin
         int base = pow10(i);
         r[i] = m_dir[k] ? ((m_val[k] % base) == base - 1) : ((m_val[k] % base) == 0);
      end
      return r;
   endfunction

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int k = 0; k < 2; k++) begin
            m_state[k] <= S_IDLE; m_pre[k] <= 0; m_dir[k] <= 1'b1;
            m_err[k] <= 1'b0; m_done[k] <= 1'b0; m_preset[k] <= 8'h00;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_state[k] == S_LOAD) m_val[k] <= bcd2int(m_preset[k]);
            else if (m_en(k) != 2'b00) m_val[k] <= m_dir[k] ? (m_val[k] + 1) % (MAXV + 1) : m_val[k] - 1;
            if (m_state[k] == S_RUN) m_pre[k] <= (m_pre[k] + 1) % PRESC;
            m_done[k] <= m_tick(k) && m_term(k);
            case (m_state[k])
               S_LOAD: begin m_state[k] <= S_IDLE; m_err[k] <= 1'b0; end
               S_RUN: begin
                  if (cmd_load) begin
                     if (nibbles_ok(preset)) begin m_state[k] <= S_LOAD; m_preset[k] <= preset; end
                     else m_err[k] <= 1'b1;
                  end else if (cmd_stop) m_state[k] <= S_PAUSE;
                  else if (m_tick(k) && m_stops(k)) m_state[k] <= S_DONE;
               end
               default: begin
                  if (cmd_load) begin
                     if (nibbles_ok(preset)) begin m_state[k] <= S_LOAD; m_preset[k] <= preset; end
                     else m_err[k] <= 1'b1;
                  end else if (!cmd_stop && cmd_start &&
                               !(m_state[k] == S_DONE && !dir_up && m_val[k] == 0)) begin
                     m_state[k] <= S_RUN;
                     m_dir[k]   <= dir_up;
                     if (m_state[k] != S_PAUSE) m_pre[k] <= 0;
                  end
               end
            endcase
         end
      end
   end

   task automatic go(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_load(logic [7:0] v);
      preset = v; cmd_load = 1'b1; go(1); cmd_load = 1'b0;
   endtask

   task automatic pulse_start(logic d);
      dir_up = d; cmd_start = 1'b1; go(1); cmd_start = 1'b0;
   endtask

   task automatic test_reset;
      clr = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_load = 1'b0; dir_up = 1'b0; preset = 8'h00;
      dq[0] = 8'h00; dq[1] = 8'h00;
      go(2);
      for (int k = 0; k < 2; k++) begin
         checks++; if (st[k] !== 3'd0) begin errors++; $display("FAIL reset_state k=%0d got %0d exp 0", k, st[k]); end
         checks++; if ({bz[k], dn[k], er[k], ld[k]} !== 4'b0000) begin errors++; $display("FAIL reset_flags k=%0d got %b exp 0000", k, {bz[k], dn[k], er[k], ld[k]}); end
         checks++; if (en[k] !== 2'b00) begin errors++; $display("FAIL reset_en k=%0d got %b exp 00", k, en[k]); end
         checks++; if (up[k] !== 1'b1) begin errors++; $display("FAIL reset_up k=%0d got %b exp 1", k, up[k]); end
         checks++; if (dd[k] !== 8'h00) begin errors++; $display("FAIL reset_d k=%0d got %h exp 00", k, dd[k]); end
      end
      clr = 1'b1;
      go(1);
   endtask

   task automatic test_count_up;
      pulse_load(8'h37);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], ld[k], en[k]} !== {3'd1, 1'b1, 2'b11}) begin errors++; $display("FAIL up_loadcyc k=%0d got st%0d ld%b en%b exp st1 ld1 en11", k, st[k], ld[k], en[k]); end
         checks++; if (dd[k] !== 8'h37) begin errors++; $display("FAIL up_loadd k=%0d got %h exp 37", k, dd[k]); end
      end
      go(1);
      pulse_start(1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], bz[k], up[k]} !== {3'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL up_run k=%0d got st%0d bz%b up%b exp st2 bz1 up1", k, st[k], bz[k], up[k]); end
      end
      for (int t = 0; t < 3; t++) begin
         go(2);
         for (int k = 0; k < 2; k++) begin
            checks++; if (en[k] !== 2'b00) begin errors++; $display("FAIL up_notick k=%0d t=%0d got %b exp 00", k, t, en[k]); end
         end
         go(1);
         for (int k = 0; k < 2; k++) begin
            checks++; if (en[k] !== ((t == 2) ? 2'b11 : 2'b01)) begin errors++; $display("FAIL up_tick_en k=%0d t=%0d got %b", k, t, en[k]); end
         end
         go(1);
         for (int k = 0; k < 2; k++) begin
            checks++; if (dq[k] !== ((t == 0) ? 8'h38 : (t == 1) ? 8'h39 : 8'h40)) begin errors++; $display("FAIL up_q k=%0d t=%0d got %h", k, t, dq[k]); end
         end
      end
      cmd_stop = 1'b1; go(1); cmd_stop = 1'b0;
   endtask

   task automatic test_count_down;
      pulse_load(8'h02); go(1);
      pulse_start(1'b0);
      for (int t = 0; t < 2; t++) begin
         go(3);
         for (int k = 0; k < 2; k++) begin
            checks++; if (en[k] !== 2'b01) begin errors++; $display("FAIL dn_tick_en k=%0d t=%0d got %b exp 01", k, t, en[k]); end
         end
         go(1);
         for (int k = 0; k < 2; k++) begin
            checks++; if (dq[k] !== ((t == 0) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL dn_q k=%0d t=%0d got %h", k, t, dq[k]); end
         end
      end
      go(3);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({en[k], dn[k]} !== 3'b000) begin errors++; $display("FAIL dn_term k=%0d got en%b done%b exp en00 done0", k, en[k], dn[k]); end
      end
      go(1);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], dn[k], bz[k]} !== {3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL dn_done k=%0d got st%0d dn%b bz%b exp st4 dn1 bz0", k, st[k], dn[k], bz[k]); end
         checks++; if (dq[k] !== 8'h00) begin errors++; $display("FAIL dn_hold k=%0d got %h exp 00", k, dq[k]); end
      end
      go(1);
      for (int k = 0; k < 2; k++) begin
         checks++; if (dn[k] !== 1'b0) begin errors++; $display("FAIL dn_pulse k=%0d got %b exp 0", k, dn[k]); end
      end
      pulse_start(1'b0);
      go(1);
      for (int k = 0; k < 2; k++) begin
         checks++; if (st[k] !== 3'd4) begin errors++; $display("FAIL dn_restart k=%0d got %0d exp 4", k, st[k]); end
      end
   endtask

   task automatic test_wrap;
      pulse_load(8'h98); go(1);
      pulse_start(1'b1);
      go(4);
      go(3);
      checks++; if (en[0] !== 2'b00) begin errors++; $display("FAIL wrap0_en got %b exp 00", en[0]); end
      checks++; if (en[1] !== 2'b11) begin errors++; $display("FAIL wrap1_en got %b exp 11", en[1]); end
      go(1);
      checks++; if ({st[0], dn[0], bz[0], dq[0]} !== {3'd4, 1'b1, 1'b0, 8'h99}) begin errors++; $display("FAIL wrap0_done got st%0d dn%b bz%b q%h exp st4 dn1 bz0 q99", st[0], dn[0], bz[0], dq[0]); end
      checks++; if ({st[1], dn[1], bz[1], dq[1]} !== {3'd2, 1'b1, 1'b1, 8'h00}) begin errors++; $display("FAIL wrap1_roll got st%0d dn%b bz%b q%h exp st2 dn1 bz1 q00", st[1], dn[1], bz[1], dq[1]); end
   endtask

   task automatic test_invalid_load;
      pulse_load(8'h00); go(1);
      pulse_load(8'h3A);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 2; k++) begin
            checks++; if ({er[k], st[k], ld[k]} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL bad_load k=%0d c=%0d got er%b st%0d ld%b exp er1 st0 ld0", k, c, er[k], st[k], ld[k]); end
         end
         go(1);
      end
      pulse_load(8'h12); go(1);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({er[k], dq[k]} !== {1'b0, 8'h12}) begin errors++; $display("FAIL err_clear k=%0d got er%b q%h exp er0 q12", k, er[k], dq[k]); end
      end
   endtask

   task automatic test_pause_resume;
      pulse_start(1'b1);
      go(2);
      cmd_stop = 1'b1; go(1); cmd_stop = 1'b0;
      go(10);
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], bz[k], en[k], dq[k]} !== {3'd3, 1'b0, 2'b00, 8'h12}) begin errors++; $display("FAIL pause k=%0d got st%0d bz%b en%b q%h", k, st[k], bz[k], en[k], dq[k]); end
      end
      pulse_start(1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++; if (en[k] !== 2'b01) begin errors++; $display("FAIL resume_tick k=%0d got %b exp 01", k, en[k]); end
      end
      go(1);
      for (int k = 0; k < 2; k++) begin
         checks++; if (dq[k] !== 8'h13) begin errors++; $display("FAIL resume_q k=%0d got %h exp 13", k, dq[k]); end
      end
   endtask

   task automatic test_priority;
      preset = 8'h55; cmd_load = 1'b1; cmd_stop = 1'b1; go(1); cmd_load = 1'b0; cmd_stop = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], dd[k]} !== {3'd1, 8'h55}) begin errors++; $display("FAIL prio_load k=%0d got st%0d d%h exp st1 d55", k, st[k], dd[k]); end
      end
      go(1);
      cmd_stop = 1'b1; cmd_start = 1'b1; go(1); cmd_stop = 1'b0; cmd_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], dq[k]} !== {3'd0, 8'h55}) begin errors++; $display("FAIL prio_stop k=%0d got st%0d q%h exp st0 q55", k, st[k], dq[k]); end
      end
   endtask

   task automatic test_reset_midrun;
      pulse_start(1'b1);
      go(3);
      for (int k = 0; k < 2; k++) begin
         checks++; if (en[k] !== 2'b01) begin errors++; $display("FAIL rst_pre_en k=%0d got %b exp 01", k, en[k]); end
      end
      clr = 1'b0; #1;
      for (int k = 0; k < 2; k++) begin
         checks++; if ({st[k], bz[k], en[k], ld[k], up[k], dd[k], dn[k], er[k]} !== {3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_async k=%0d got st%0d bz%b en%b ld%b up%b d%h", k, st[k], bz[k], en[k], ld[k], up[k], dd[k]); end
         checks++; if (dq[k] !== 8'h55) begin errors++; $display("FAIL rst_chain k=%0d got %h exp 55", k, dq[k]); end
      end
      go(1);
      clr = 1'b1;
      for (int c = 0; c < 6; c++) begin
         go(1);
         for (int k = 0; k < 2; k++) begin
            checks++; if ({st[k], en[k]} !== {3'd0, 2'b00}) begin errors++; $display("FAIL rst_idle k=%0d c=%0d got st%0d en%b", k, c, st[k], en[k]); end
         end
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         clr       = ($urandom_range(0, 249) != 0);
         cmd_load  = ($urandom_range(0, 19) == 0);
         cmd_stop  = ($urandom_range(0, 15) == 0);
         cmd_start = ($urandom_range(0, 5) == 0);
         dir_up    = 1'($urandom_range(0, 1));
         preset    = ($urandom_range(0, 3) != 0) ? int2bcd($urandom_range(0, 99)) : 8'($urandom);
         go(1);
         for (int k = 0; k < 2; k++) begin
            checks++; if (st[k] !== 3'(m_state[k])) begin errors++; $display("FAIL rnd_state k=%0d c=%0d got %0d exp %0d", k, c, st[k], m_state[k]); end
            checks++; if (bz[k] !== (m_state[k] == S_RUN)) begin errors++; $display("FAIL rnd_busy k=%0d c=%0d got %b", k, c, bz[k]); end
            checks++; if (dn[k] !== m_done[k]) begin errors++; $display("FAIL rnd_done k=%0d c=%0d got %b exp %b", k, c, dn[k], m_done[k]); end
            checks++; if (er[k] !== m_err[k]) begin errors++; $display("FAIL rnd_err k=%0d c=%0d got %b exp %b", k, c, er[k], m_err[k]); end
            checks++; if (en[k] !== m_en(k)) begin errors++; $display("FAIL rnd_en k=%0d c=%0d got %b exp %b", k, c, en[k], m_en(k)); end
            checks++; if (ld[k] !== (m_state[k] == S_LOAD)) begin errors++; $display("FAIL rnd_load k=%0d c=%0d got %b", k, c, ld[k]); end
            checks++; if (up[k] !== m_dir[k]) begin errors++; $display("FAIL rnd_up k=%0d c=%0d got %b exp %b", k, c, up[k], m_dir[k]); end
            checks++; if (dd[k] !== ((m_state[k] == S_LOAD) ? m_preset[k] : 8'h00)) begin errors++; $display("FAIL rnd_d k=%0d c=%0d got %h", k, c, dd[k]); end
            checks++; if (dq[k] !== int2bcd(m_val[k])) begin errors++; $display("FAIL rnd_q k=%0d c=%0d got %h exp %h", k, c, dq[k], int2bcd(m_val[k])); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_count_up;
      test_count_down;
      test_wrap;
      test_invalid_load;
      test_pause_resume;
      test_priority;
      test_reset_midrun;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
